// File: rtl/cmd_regfile_pkg.sv
// cmd_regfile_pkg: register addresses, CTRL bit positions and gate states
package cmd_regfile_pkg;
  localparam logic [7:0] ADDR_SCRATCH  = 8'h00;
  localparam logic [7:0] ADDR_CTRL     = 8'h01;
  localparam logic [7:0] ADDR_CHEN     = 8'h02;
  localparam logic [7:0] ADDR_MODE     = 8'h03;
  localparam logic [7:0] ADDR_GATE_LEN = 8'h10;
  localparam logic [7:0] ADDR_USER32   = 8'h11;
  localparam logic [7:0] ADDR_CNT      = 8'h12;
  localparam logic [7:0] ADDR_STATUS   = 8'h13;
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 2;
  localparam int CTRL_CLEAR = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} gate_state_e;
endpackage

// File: rtl/cmd_regfile_strobe_fall_detect.sv
// strobe_fall_detect: registers a stretched strobe and flags the cycle it falls
module strobe_fall_detect (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic strobe,
  output logic fall
);
  logic strobe_d;
  // delayed copy of the strobe; a synchronous clear discards any fall in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) strobe_d <= 1'b0;
    else strobe_d <= clear ? 1'b0 : strobe;
  assign fall = strobe_d & ~strobe;
endmodule

// File: rtl/cmd_regfile.sv
// cmd_regfile: control register bank, CTRL action pulses, counting gate and readback
module cmd_regfile
  import cmd_regfile_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 200000000,
  parameter logic [31:0] GATE_DEFAULT = 32'd200000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        soft_reset,
  input  logic [7:0]  addr,
  input  logic        sw_in,
  input  logic [7:0]  data_in,
  input  logic        sw_in32,
  input  logic [31:0] data_in32,
  input  logic [7:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [7:0]  ch_enable,
  output logic [7:0]  mode,
  output logic        gate,
  output logic        start_pulse,
  output logic        clear_pulse,
  output logic        done_pulse,
  output logic        busy
);
  gate_state_e state, state_n;
  logic [31:0] cnt, cnt_n, gate_len, user32, rd_next;
  logic [7:0] scratch;
  logic fall8, fall32, pend, pend_n, done_seen;
  logic ctrl_wr, req_start, req_stop, req_clear, start_ok;
  logic unused_clk_freq;
  assign unused_clk_freq = CLK_FREQ != 0;

  strobe_fall_detect u_fall8 (.clk(clk), .reset(reset), .clear(soft_reset), .strobe(sw_in), .fall(fall8));
  strobe_fall_detect u_fall32 (.clk(clk), .reset(reset), .clear(soft_reset), .strobe(sw_in32), .fall(fall32));

  assign ctrl_wr   = fall8 && addr == ADDR_CTRL;
  assign req_start = ctrl_wr && data_in[CTRL_START];
  assign req_stop  = ctrl_wr && data_in[CTRL_STOP];
  assign req_clear = ctrl_wr && data_in[CTRL_CLEAR];
  assign start_ok  = req_start && !req_stop && state != ST_RUN;

  assign gate       = state == ST_RUN;
  assign busy       = gate;
  assign done_pulse = state == ST_DONE;

  // next gate state; later lines win: countdown expiry, zero-length done, STOP, accepted START
  always_comb begin
    state_n = state;
    cnt_n = state == ST_RUN ? cnt - 32'd1 : cnt;
    pend_n = start_ok && gate_len == '0;
    if (state == ST_RUN && cnt == 32'd1) state_n = ST_DONE;
    if (state == ST_DONE) state_n = ST_IDLE;
    if (pend) state_n = ST_DONE;
    if (req_stop) state_n = ST_IDLE;
    if (start_ok) begin
      state_n = gate_len == '0 ? ST_IDLE : ST_RUN;
      cnt_n = gate_len;
    end
  end

  // gate state, live down-counter and the zero-length pending flag
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      pend <= 1'b0;
    end else if (soft_reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      pend <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pend <= pend_n;
    end

  assign rd_next = rd_addr == ADDR_SCRATCH  ? {24'd0, scratch}
                 : rd_addr == ADDR_CHEN     ? {24'd0, ch_enable}
                 : rd_addr == ADDR_MODE     ? {24'd0, mode}
                 : rd_addr == ADDR_GATE_LEN ? gate_len
                 : rd_addr == ADDR_USER32   ? user32
                 : rd_addr == ADDR_CNT      ? cnt
                 : rd_addr == ADDR_STATUS   ? {29'd0, done_seen, busy, gate}
                 : '0;

  // register commits on strobe fall, action pulses, sticky done flag and readback
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      scratch <= '0;
      ch_enable <= 8'hFF;
      mode <= '0;
      gate_len <= GATE_DEFAULT;
      user32 <= '0;
      start_pulse <= 1'b0;
      clear_pulse <= 1'b0;
      done_seen <= 1'b0;
      rd_data <= '0;
    end else if (soft_reset) begin
      scratch <= '0;
      ch_enable <= 8'hFF;
      mode <= '0;
      gate_len <= GATE_DEFAULT;
      user32 <= '0;
      start_pulse <= 1'b0;
      clear_pulse <= 1'b0;
      done_seen <= 1'b0;
      rd_data <= '0;
    end else begin
      if (fall8 && addr == ADDR_SCRATCH) scratch <= data_in;
      if (fall8 && addr == ADDR_CHEN) ch_enable <= data_in;
      if (fall8 && addr == ADDR_MODE) mode <= data_in;
      if (fall32 && addr == ADDR_GATE_LEN) gate_len <= data_in32;
      if (fall32 && addr == ADDR_USER32) user32 <= data_in32;
      start_pulse <= start_ok;
      clear_pulse <= req_clear;
      done_seen <= !(req_clear || req_start) && (done_seen || state == ST_DONE);
      rd_data <= rd_next;
    end
endmodule

// File: tb/tb_cmd_regfile.sv
// tb_cmd_regfile: randomized scoreboard bench for cmd_regfile
module tb_cmd_regfile;
  localparam logic [31:0] GDEF = 32'd200000000;
  logic clk = 0, reset = 0, soft_reset = 0, sw_in = 0, sw_in32 = 0;
  logic [7:0] addr = 0, data_in = 0, rd_addr = 0;
  logic [31:0] data_in32 = 0;
  logic [31:0] rd_data;
  logic [7:0] ch_enable, mode;
  logic gate, start_pulse, clear_pulse, done_pulse, busy;
  int errors = 0, checks = 0, cyc = 0, run = 0;
  typedef struct packed {logic [7:0] a; logic [31:0] lo; logic [31:0] hi;} rd_exp_t;
  rd_exp_t rdq[$];
  rd_exp_t e;
  int sq[$], dq[$], cq[$], gq[$];
  logic rd_req = 0, rv = 0;
  logic [7:0] m_scr, m_chen, m_mode;
  logic [31:0] m_glen, m_user;
  int m_start = -100, m_end = -100;
  int c, s, op, n, k;
  logic [7:0] a;

  cmd_regfile #(.CLK_FREQ(200000000), .GATE_DEFAULT(GDEF)) dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset), .addr(addr), .sw_in(sw_in),
    .data_in(data_in), .sw_in32(sw_in32), .data_in32(data_in32), .rd_addr(rd_addr),
    .rd_data(rd_data), .ch_enable(ch_enable), .mode(mode), .gate(gate),
    .start_pulse(start_pulse), .clear_pulse(clear_pulse), .done_pulse(done_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rv <= rd_req;
  end

  // monitor: pops expectations whenever the DUT presents readback, pulses or a finished gate
  always @(negedge clk) begin
    if (rv) begin
      checks++;
      if (rdq.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected rd_data=%h", rd_data);
      end else begin
        e = rdq.pop_front();
        if (rd_data < e.lo || rd_data > e.hi) begin
          errors++;
          $display("FAIL read_%h got=%h want=%h..%h", e.a, rd_data, e.lo, e.hi);
        end
      end
    end
    if (sq.size() && sq[0] < cyc) begin
      checks++; errors++;
      $display("FAIL start_pulse missing got=0 want=1 at cycle %0d", sq.pop_front());
    end
    if (start_pulse) begin
      checks++;
      if (sq.size() == 0 || sq[0] != cyc) begin
        errors++;
        $display("FAIL start_pulse at cycle %0d want cycle %0d", cyc, sq.size() ? sq[0] : -1);
      end
      if (sq.size()) void'(sq.pop_front());
    end
    if (dq.size() && dq[0] < cyc) begin
      checks++; errors++;
      $display("FAIL done_pulse missing got=0 want=1 at cycle %0d", dq.pop_front());
    end
    if (done_pulse) begin
      checks++;
      if (dq.size() == 0 || dq[0] != cyc) begin
        errors++;
        $display("FAIL done_pulse at cycle %0d want cycle %0d", cyc, dq.size() ? dq[0] : -1);
      end
      if (dq.size()) void'(dq.pop_front());
    end
    if (cq.size() && cq[0] < cyc) begin
      checks++; errors++;
      $display("FAIL clear_pulse missing got=0 want=1 at cycle %0d", cq.pop_front());
    end
    if (clear_pulse) begin
      checks++;
      if (cq.size() == 0 || cq[0] != cyc) begin
        errors++;
        $display("FAIL clear_pulse at cycle %0d want cycle %0d", cyc, cq.size() ? cq[0] : -1);
      end
      if (cq.size()) void'(cq.pop_front());
    end
    checks++;
    if (busy !== gate) begin
      errors++;
      $display("FAIL busy got=%b want=%b", busy, gate);
    end
    if (gate) run++;
    else if (run > 0) begin
      checks++;
      if (gq.size() == 0 || gq[0] != run) begin
        errors++;
        $display("FAIL gate_len got=%0d cycles want=%0d", run, gq.size() ? gq[0] : -1);
      end
      if (gq.size()) void'(gq.pop_front());
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic m_defaults();
    m_scr = 0; m_chen = 8'hFF; m_mode = 0; m_glen = GDEF; m_user = 0;
  endtask

  function automatic logic [31:0] m_rd(input logic [7:0] ra);
    case (ra)
      8'h00: return {24'd0, m_scr};
      8'h02: return {24'd0, m_chen};
      8'h03: return {24'd0, m_mode};
      8'h10: return m_glen;
      8'h11: return m_user;
      default: return 32'd0;
    endcase
  endfunction

  task automatic rd(input logic [7:0] ra, input logic [31:0] lo, input logic [31:0] hi);
    rd_addr = ra;
    rd_req = 1;
    rdq.push_back('{ra, lo, hi});
    tick();
    rd_req = 0;
  endtask

  task automatic rde(input logic [7:0] ra);
    rd(ra, m_rd(ra), m_rd(ra));
  endtask

  // the gate is forced low from cycle fc on, if it was open in the cycle before
  task automatic cut(input int fc);
    if (fc - 1 >= m_start && fc - 1 <= m_end) begin
      void'(gq.pop_back());
      void'(dq.pop_back());
      gq.push_back(fc - m_start);
      m_end = fc - 1;
    end
  endtask

  task automatic ctrl(input logic [7:0] d, input int cc);
    bit bsy;
    bsy = (cc - 1 >= m_start) && (cc - 1 <= m_end);
    if (d[3]) cq.push_back(cc);
    if (d[2]) cut(cc);
    else if (d[0] && !bsy) begin
      sq.push_back(cc);
      m_start = cc;
      if (m_glen == 0) begin
        dq.push_back(cc + 1);
        m_end = cc - 1;
      end else begin
        gq.push_back(int'(m_glen));
        dq.push_back(cc + int'(m_glen));
        m_end = cc + int'(m_glen) - 1;
      end
    end
  endtask

  task automatic wr(input bit w32, input logic [7:0] wa, input logic [31:0] d, input int len, output int cc);
    addr = wa;
    data_in = d[7:0];
    data_in32 = d;
    if (w32) sw_in32 = 1;
    else sw_in = 1;
    repeat (len) tick();
    sw_in = 0;
    sw_in32 = 0;
    tick();
    cc = cyc;
    if (w32) begin
      if (wa == 8'h10) m_glen = d;
      if (wa == 8'h11) m_user = d;
    end else if (wa == 8'h00) m_scr = d[7:0];
    else if (wa == 8'h01) ctrl(d[7:0], cc);
    else if (wa == 8'h02) m_chen = d[7:0];
    else if (wa == 8'h03) m_mode = d[7:0];
  endtask

  initial begin
    m_defaults();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {rd_data, ch_enable, mode, gate, start_pulse, clear_pulse, done_pulse, busy},
        {32'd0, 8'hFF, 8'h00, 5'b0});
    reset = 1;
    tick();
    rd(8'h02, 32'hFF, 32'hFF);
    rde(8'h10);
    rd(8'h13, 0, 0);
    rde(8'h00);
    rd(8'h01, 0, 0);
    addr = 8'h03; data_in = 8'h5A; sw_in = 1;
    repeat (80) tick();
    chk("mode_before_fall", mode, 8'h00);
    sw_in = 0;
    tick();
    chk("mode_after_fall", mode, 8'h5A);
    m_mode = 8'h5A;
    repeat (5) tick();
    chk("mode_one_commit", mode, 8'h5A);
    rd(8'h03, 32'h5A, 32'h5A);
    wr(1, 8'h10, 10, 3, c);
    wr(0, 8'h01, 8'h01, 2, c);
    repeat (20) tick();
    rd(8'h13, 4, 4);
    wr(1, 8'h10, 1000, 3, c);
    wr(0, 8'h01, 8'h01, 2, s);
    repeat (40) tick();
    wr(0, 8'h01, 8'h01, 3, c);
    repeat (300 - 44 - 5) tick();
    wr(0, 8'h01, 8'h04, 4, c);
    rd(8'h12, 695, 705);
    rd(8'h13, 0, 0);
    wr(1, 8'h10, 0, 2, c);
    wr(0, 8'h01, 8'h01, 2, c);
    repeat (5) tick();
    rd(8'h13, 4, 4);
    wr(0, 8'h01, 8'h0D, 2, c);
    repeat (3) tick();
    rd(8'h13, 0, 0);
    wr(1, 8'h10, 5, 2, c);
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 4);
      n = $urandom_range(1, 8);
      if (op == 0) begin
        k = $urandom_range(0, 3);
        a = k == 1 ? 8'($urandom_range(4, 255)) : 8'(k);
        wr(0, a, $urandom, n, c);
      end else if (op == 1) begin
        k = $urandom_range(0, 2);
        a = k == 0 ? 8'h10 : k == 1 ? 8'h11 : 8'($urandom_range(18, 255));
        wr(1, a, k == 0 ? $urandom_range(0, 30) : $urandom, n, c);
      end else if (op == 2) wr(0, 8'h01, $urandom & 32'h0F, n, c);
      else if (op == 3) begin
        k = $urandom_range(0, 6);
        a = k < 4 ? 8'(k) : k == 4 ? 8'h10 : k == 5 ? 8'h11 : 8'($urandom_range(20, 255));
        rde(a);
      end else repeat (n * 2) tick();
    end
    repeat (60) tick();
    wr(1, 8'h10, 500, 2, c);
    wr(0, 8'h01, 8'h01, 2, c);
    repeat (20) tick();
    soft_reset = 1;
    tick();
    cut(cyc);
    m_defaults();
    chk("gate_soft_reset", gate, 1'b0);
    addr = 8'h03; data_in = 8'h77; sw_in = 1;
    repeat (10) tick();
    sw_in = 0;
    repeat (188) tick();
    soft_reset = 0;
    tick();
    chk("regs_after_soft_reset", {ch_enable, mode}, {8'hFF, 8'h00});
    rde(8'h03);
    rde(8'h10);
    rd(8'h02, 32'hFF, 32'hFF);
    rd(8'h13, 0, 0);
    wr(1, 8'h10, 100, 2, c);
    wr(0, 8'h01, 8'h01, 2, c);
    repeat (10) tick();
    #2;
    reset = 0;
    cut(cyc);
    m_defaults();
    #1;
    chk("async_reset_outputs", {rd_data, ch_enable, gate, done_pulse}, {32'd0, 8'hFF, 2'b0});
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    tick();
    rd(8'h02, 32'hFF, 32'hFF);
    rde(8'h10);
    repeat (20) tick();
    chk("reads_pending", rdq.size(), 0);
    chk("starts_pending", sq.size(), 0);
    chk("dones_pending", dq.size(), 0);
    chk("clears_pending", cq.size(), 0);
    chk("gates_pending", gq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
